// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared decode types, opcodes and source-usage helpers
package core_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_BRANCH, ALU_FUNCT, ALU_FUNCT_IMM} alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     rd_data1;
    logic [DATA_WIDTH-1:0]     rd_data2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic                      RegWrite;
    logic                      MemRead;
    logic                      MemWrite;
    logic                      Branch;
    logic                      Jump;
    logic                      ALUSrc;
    src_a_e                    ALUSrcA;
    alu_op_e                   ALUOp;
    wb_sel_e                   WBSel;
  } id_ex_data_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP || opcode == STORE || opcode == BRANCH);
  endfunction

endpackage

// File: rtl/immediate_generator.sv
// rtl/immediate_generator.sv - sign-extended immediate for each RV32 format
module immediate_generator
  import core_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_sel_e    imm_sel,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/main_control_unit.sv
// rtl/main_control_unit.sv - opcode to control-signal decode
module main_control_unit
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       ALUSrc,
  output src_a_e     ALUSrcA,
  output alu_op_e    ALUOp,
  output wb_sel_e    WBSel,
  output imm_sel_e   ImmSel
);

  always_comb begin
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    ALUSrc   = 1'b0;
    ALUSrcA  = SRC_A_RS1;
    ALUOp    = ALU_ADD;
    WBSel    = WB_ALU;
    ImmSel   = IMM_I;
    case (opcode)
      OP: begin
        RegWrite = 1'b1;
        ALUOp    = ALU_FUNCT;
      end
      OP_IMM: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = ALU_FUNCT_IMM;
      end
      LOAD: begin
        RegWrite = 1'b1;
        MemRead  = 1'b1;
        ALUSrc   = 1'b1;
        WBSel    = WB_MEM;
      end
      STORE: begin
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
        ImmSel   = IMM_S;
      end
      BRANCH: begin
        Branch = 1'b1;
        ALUOp  = ALU_BRANCH;
        ImmSel = IMM_B;
      end
      JAL: begin
        RegWrite = 1'b1;
        Jump     = 1'b1;
        ALUSrcA  = SRC_A_PC;
        ALUSrc   = 1'b1;
        WBSel    = WB_PC4;
        ImmSel   = IMM_J;
      end
      JALR: begin
        RegWrite = 1'b1;
        Jump     = 1'b1;
        ALUSrc   = 1'b1;
        WBSel    = WB_PC4;
      end
      LUI: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUSrcA  = SRC_A_ZERO;
        ImmSel   = IMM_U;
      end
      AUIPC: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUSrcA  = SRC_A_PC;
        ImmSel   = IMM_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_bp.sv
// rtl/regfile_bp.sv - 2R1W integer register file, x0 hardwired, optional write-through bypass
module regfile_bp
  import core_pkg::*;
#(
  parameter int XLEN      = DATA_WIDTH,
  parameter int RA_W      = REG_ADDR_WIDTH,
  parameter int BYPASS_EN = 1,
  parameter int RF_RESET  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd
);

  localparam int NREGS = 2**RA_W;

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  generate
    if (RF_RESET != 0) begin : g_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 1; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
          regs[wa] <= wd;
        end
      end
    end else begin : g_nrst
      always_ff @(posedge clk) begin
        if (wr_en) regs[wa] <= wd;
      end
    end
  endgenerate

  // wr_en already excludes x0, so the bypass never leaks data onto x0
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) rd1 = ((BYPASS_EN != 0) && wr_en && (wa == ra1)) ? wd : regs[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) rd2 = ((BYPASS_EN != 0) && wr_en && (wa == ra2)) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered decode stage with valid/ready handshake,
// load-use interlock against the held instruction, and flush.
module id_stage_pipe
  import core_pkg::*;
#(
  parameter int XLEN      = DATA_WIDTH,
  parameter int RA_W      = REG_ADDR_WIDTH,
  parameter int BYPASS_EN = 1,
  parameter int HAZARD_EN = 1,
  parameter int RF_RESET  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_pc_plus4_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output id_ex_data_t     out_data_o,
  output logic            stall_o
);

  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [31:0]     imm;

  logic     RegWrite, MemRead, MemWrite, Branch, Jump, ALUSrc;
  src_a_e   ALUSrcA;
  alu_op_e  ALUOp;
  wb_sel_e  WBSel;
  imm_sel_e ImmSel;

  logic        load_dep, hazard, in_xfer, out_xfer;
  id_ex_data_t dec;

  assign opcode = in_instr_i[6:0];
  assign rd     = in_instr_i[7 +: RA_W];
  assign rs1    = in_instr_i[15 +: RA_W];
  assign rs2    = in_instr_i[20 +: RA_W];

  main_control_unit u_ctrl (
    .opcode   (opcode),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .Jump     (Jump),
    .ALUSrc   (ALUSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUOp    (ALUOp),
    .WBSel    (WBSel),
    .ImmSel   (ImmSel)
  );

  immediate_generator u_imm (
    .instr   (in_instr_i),
    .imm_sel (ImmSel),
    .imm     (imm)
  );

  regfile_bp #(
    .XLEN      (XLEN),
    .RA_W      (RA_W),
    .BYPASS_EN (BYPASS_EN),
    .RF_RESET  (RF_RESET)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_we_i),
    .wa  (wb_addr_i),
    .wd  (wb_data_i)
  );

  // Only the held instruction can be a load still in flight; older loads have already left.
  assign load_dep = in_valid_i && out_valid_o && out_data_o.MemRead && (out_data_o.rd_addr != '0) &&
                    ((uses_rs1(opcode) && (rs1 == out_data_o.rd_addr)) ||
                     (uses_rs2(opcode) && (rs2 == out_data_o.rd_addr)));
  assign hazard   = (HAZARD_EN != 0) && load_dep;

  assign in_ready_o = !hazard && (!out_valid_o || out_ready_i);
  assign stall_o    = hazard && out_ready_i;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = out_valid_o && out_ready_i;

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc_i;
    dec.pc_plus4 = in_pc_plus4_i;
    dec.rd_data1 = rf_rd1;
    dec.rd_data2 = rf_rd2;
    dec.imm      = imm;
    dec.rs1_addr = rs1;
    dec.rs2_addr = rs2;
    dec.rd_addr  = RegWrite ? rd : '0;
    dec.funct3   = in_instr_i[14:12];
    dec.funct7   = in_instr_i[31:25];
    dec.RegWrite = RegWrite;
    dec.MemRead  = MemRead;
    dec.MemWrite = MemWrite;
    dec.Branch   = Branch;
    dec.Jump     = Jump;
    dec.ALUSrc   = ALUSrc;
    dec.ALUSrcA  = ALUSrcA;
    dec.ALUOp    = ALUOp;
    dec.WBSel    = WBSel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (in_xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= dec;
    end else if (out_xfer) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed decode-stage bench with a behavioural
// hazard/register-file model compared every cycle, plus literal spot checks.
module tb_id_stage_pipe;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pc4;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, stall;
  id_ex_data_t out_data;
  logic        in_ready_nb, out_valid_nb, stall_nb;
  id_ex_data_t out_data_nb;

  assign in_pc4 = in_pc + 32'd4;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk (clk), .rst (rst),
    .in_valid_i (in_valid), .in_ready_o (in_ready), .in_instr_i (in_instr),
    .in_pc_i (in_pc), .in_pc_plus4_i (in_pc4), .flush_i (flush),
    .wb_we_i (wb_we), .wb_addr_i (wb_addr), .wb_data_i (wb_data),
    .out_valid_o (out_valid), .out_ready_i (out_ready), .out_data_o (out_data),
    .stall_o (stall)
  );

  id_stage_pipe #(.BYPASS_EN(0)) dut_nb (
    .clk (clk), .rst (rst),
    .in_valid_i (in_valid), .in_ready_o (in_ready_nb), .in_instr_i (in_instr),
    .in_pc_i (in_pc), .in_pc_plus4_i (in_pc4), .flush_i (flush),
    .wb_we_i (wb_we), .wb_addr_i (wb_addr), .wb_data_i (wb_data),
    .out_valid_o (out_valid_nb), .out_ready_i (out_ready), .out_data_o (out_data_nb),
    .stall_o (stall_nb)
  );

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural view of the stage: decode rules straight from the ISA table
  function automatic bit writes_rd(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [31:0] w);
    return !(w[6:0] == 7'h37 || w[6:0] == 7'h17 || w[6:0] == 7'h6f);
  endfunction

  function automatic bit reads_rs2(input logic [31:0] w);
    return (w[6:0] == 7'h33 || w[6:0] == 7'h23 || w[6:0] == 7'h63);
  endfunction

  logic [31:0] rf [32];
  logic [31:0] cur_imm = '0;
  logic        cur_chk = 1'b0;

  function automatic logic [31:0] mread(input logic [4:0] a, input bit bp);
    if (a == 5'd0) return 32'd0;
    if (bp && wb_we && wb_addr == a) return wb_data;
    return rf[a];
  endfunction

  logic        m_valid, m_load, m_regw, m_chk;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_imm, m_d1, m_d2, m_d1nb, m_d2nb;
  logic        last_stall, last_in_ready;
  logic [31:0] pc_log [$];

  initial begin
    logic hz, erdy;
    m_valid = 1'b0; m_load = 1'b0; m_regw = 1'b0; m_chk = 1'b0; m_rd = '0;
    m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0; m_d1nb = '0; m_d2nb = '0;
    last_stall = 1'b0; last_in_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
      end else begin
        check1("valid", out_valid, m_valid);
        check1("valid_nb", out_valid_nb, m_valid);
        if (m_valid) begin
          check32("pc", out_data.pc, m_pc);
          check32("pc_plus4", out_data.pc_plus4, m_pc + 32'd4);
          check32("rd_addr", 32'(out_data.rd_addr), 32'(m_rd));
          check32("rd_data1", out_data.rd_data1, m_d1);
          check32("rd_data2", out_data.rd_data2, m_d2);
          check1("MemRead", out_data.MemRead, m_load);
          check1("RegWrite", out_data.RegWrite, m_regw);
          if (m_chk) check32("imm", out_data.imm, m_imm);
          check32("pc_nb", out_data_nb.pc, m_pc);
          check32("rd_data1_nb", out_data_nb.rd_data1, m_d1nb);
          check32("rd_data2_nb", out_data_nb.rd_data2, m_d2nb);
        end
        hz = m_valid && m_load && (m_rd != 5'd0) && in_valid &&
             ((reads_rs1(in_instr) && in_instr[19:15] == m_rd) ||
              (reads_rs2(in_instr) && in_instr[24:20] == m_rd));
        erdy = !hz && (!m_valid || out_ready);
        check1("in_ready", in_ready, erdy);
        check1("stall", stall, hz && out_ready);
        check1("in_ready_nb", in_ready_nb, erdy);
        check1("stall_nb", stall_nb, hz && out_ready);
        last_stall = stall;
        last_in_ready = in_ready;
        if (out_valid && out_ready) pc_log.push_back(out_data.pc);
        if (flush) begin
          m_valid = 1'b0;
        end else if (in_valid && erdy) begin
          m_valid = 1'b1;
          m_pc    = in_pc;
          m_regw  = writes_rd(in_instr);
          m_rd    = m_regw ? in_instr[11:7] : 5'd0;
          m_load  = (in_instr[6:0] == 7'h03);
          m_d1    = mread(in_instr[19:15], 1'b1);
          m_d2    = mread(in_instr[24:20], 1'b1);
          m_d1nb  = mread(in_instr[19:15], 1'b0);
          m_d2nb  = mread(in_instr[24:20], 1'b0);
          m_imm   = cur_imm;
          m_chk   = cur_chk;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
        if (wb_we && wb_addr != 5'd0) rf[wb_addr] = wb_data;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] imm, input logic chk);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    cur_imm  = imm;
    cur_chk  = chk;
  endtask

  initial begin
    logic [31:0] exp_log [10];
    exp_log = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                32'h114, 32'h118, 32'h200, 32'h204, 32'h300};
    #7;
    check1("reset_valid", out_valid, 1'b0);
    check1("reset_stall", stall, 1'b0);
    check1("reset_data_zero", out_data == '0, 1'b1);
    cyc();
    rst = 1'b0;

    // x5 <- 0x55 so that the later reset has something to clear
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    cyc();
    wb_we = 1'b0;

    put(32'h00500093, 32'h100, 32'd5, 1'b1);                 // addi x1,x0,5
    cyc();
    put(32'h00108133, 32'h104, 32'd0, 1'b0);                 // add x2,x1,x1
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    cyc();
    wb_we = 1'b0;
    check32("bypass_rd1", out_data.rd_data1, 32'd5);
    check32("bypass_rd2", out_data.rd_data2, 32'd5);
    check32("nobypass_rd1", out_data_nb.rd_data1, 32'd0);
    check32("nobypass_rd2", out_data_nb.rd_data2, 32'd0);

    put(32'h00002183, 32'h108, 32'd0, 1'b1);                 // lw x3,0(x0)
    cyc();
    put(32'h00018233, 32'h10C, 32'd0, 1'b0);                 // add x4,x3,x0
    cyc();
    check1("loaduse_stall", last_stall, 1'b1);
    check1("loaduse_in_ready", last_in_ready, 1'b0);
    check1("loaduse_bubble", out_valid, 1'b0);
    cyc();
    check1("loaduse_issue_valid", out_valid, 1'b1);
    check32("loaduse_issue_pc", out_data.pc, 32'h10C);
    check1("loaduse_stall_once", last_stall, 1'b0);

    put(32'h00002183, 32'h110, 32'd0, 1'b1);                 // lw x3,0(x0)
    cyc();
    put(32'h123451B7, 32'h114, 32'h12345000, 1'b1);          // lui x3,0x12345
    cyc();
    check1("lui_no_stall", last_stall, 1'b0);
    check1("lui_in_ready", last_in_ready, 1'b1);
    check32("lui_pc", out_data.pc, 32'h114);
    check32("lui_rd", 32'(out_data.rd_addr), 32'd3);

    put(32'h0050A423, 32'h118, 32'd8, 1'b1);                 // sw x5,8(x1)
    out_ready = 1'b0;
    repeat (3) begin
      cyc();
      check32("bp_hold_pc", out_data.pc, 32'h114);
      check1("bp_in_ready", last_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cyc();
    check32("sw_pc", out_data.pc, 32'h118);
    check32("sw_rd_forced", 32'(out_data.rd_addr), 32'd0);
    check32("sw_imm", out_data.imm, 32'd8);

    put(32'hFE208EE3, 32'h11C, 32'hFFFFFFFC, 1'b1);          // beq x1,x2,-4
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check1("flush_valid", out_valid, 1'b0);
    check1("flush_in_ready", last_in_ready, 1'b1);

    put(32'h008000EF, 32'h200, 32'd8, 1'b1);                 // jal x1,8
    cyc();
    check32("jal_pc", out_data.pc, 32'h200);

    put(32'h00100393, 32'h204, 32'd1, 1'b1);                 // addi x7,x0,1
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    cyc();
    wb_we = 1'b0;
    check32("x0_same_cycle", out_data.rd_data1, 32'd0);
    check32("x0_same_cycle_nb", out_data_nb.rd_data1, 32'd0);
    put(32'h00018233, 32'h208, 32'd0, 1'b0);                 // add x4,x3,x0
    cyc();
    check32("x0_later", out_data.rd_data2, 32'd0);

    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check1("async_rst_valid", out_valid, 1'b0);
    check1("async_rst_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    put(32'h00028333, 32'h300, 32'd0, 1'b0);                 // add x6,x5,x0
    cyc();
    check32("rst_x5", out_data.rd_data1, 32'd0);
    in_valid = 1'b0;
    repeat (3) cyc();

    check32("log_len", 32'(pc_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < pc_log.size()) check32($sformatf("log_pc%0d", i), pc_log[i], exp_log[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
